trigger_ctrl: RTL and testbench

Sequences one oscilloscope acquisition around the 512-sample capture buffer. It writes incoming ADC samples into a circular buffer and fills the pre-trigger window. It then detects a level/slope trigger, or forces one on auto timeout, and collects the post-trigger samples. Finally it issues the one-cycle copy request to the downstream snapshot block, waits for its ready handshake, and applies holdoff before re-arming.

---
 rtl/trigger_pkg.sv | 25 ++
 rtl/trigger_ctrl_if.sv | 40 ++++
 rtl/trigger_detect.sv | 37 +++
 rtl/trigger_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_trigger_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trigger_pkg.sv
// trigger_pkg: shared types and constants for the trigger controller slice.
// Contents: sample width, acquisition mode encodings, controller state enum.
// No logic; imported by the interface, detector and controller.
package trigger_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_SINGLE = 2'd2,
    MODE_STOP   = 2'd3
  } trig_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_FILL,
    ST_ARMED,
    ST_POST,
    ST_COPY_REQ,
    ST_COPY_WAIT,
    ST_HOLDOFF
  } trig_state_t;

endpackage

// File: rtl/trigger_ctrl_if.sv
// trigger_ctrl_if: sample stream, capture-buffer write port, snapshot handshake and status.
// Into the controller: sample_valid, sample, trig_level, trig_slope, mode, arm, copy_ready.
// Out of the controller: wr_en, wr_addr, wr_data, copy_req, trig_addr, triggered, auto_trig, busy.
interface trigger_ctrl_if #(
  parameter int DEPTH = 512
);
  import trigger_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] trig_level;
  logic                trig_slope;
  trig_mode_t          mode;
  logic                arm;
  logic                copy_ready;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [SAMPLE_W-1:0] wr_data;
  logic                copy_req;
  logic [ADDR_W-1:0]   trig_addr;
  logic                triggered;
  logic                auto_trig;
  logic                busy;

  // Environment side: drives the sample stream and controls, observes the controller.
  modport master (
    output sample_valid, sample, trig_level, trig_slope, mode, arm, copy_ready,
    input  wr_en, wr_addr, wr_data, copy_req, trig_addr, triggered, auto_trig, busy
  );

  // Controller side.
  modport slave (
    input  sample_valid, sample, trig_level, trig_slope, mode, arm, copy_ready,
    output wr_en, wr_addr, wr_data, copy_req, trig_addr, triggered, auto_trig, busy
  );

endinterface

// File: rtl/trigger_detect.sv
// trigger_detect: level/slope crossing detector against the previous valid sample.
// Latency: o_hit is combinational on the current sample; the previous sample is registered.
// Ports: i_clr drops the remembered sample, i_vld qualifies i_sample, o_hit flags a crossing.
module trigger_detect
  import trigger_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_vld,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [SAMPLE_W-1:0] i_level,
  input  logic                i_slope,
  output logic                o_hit
);

  logic [SAMPLE_W-1:0] r_prev;
  logic                r_prev_vld;
  logic                w_rise;
  logic                w_fall;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
    end else if (i_vld) begin
      r_prev     <= i_sample;
      r_prev_vld <= 1'b1;
    end
  end

  assign w_rise = (r_prev < i_level) && (i_sample >= i_level);
  assign w_fall = (r_prev > i_level) && (i_sample <= i_level);
  // Without a remembered sample there is no edge to detect.
  assign o_hit  = i_vld && r_prev_vld && (i_slope ? w_fall : w_rise);

endmodule

// File: rtl/trigger_ctrl.sv
// trigger_ctrl: sequences one scope acquisition (pre-fill, arm, post, copy, holdoff) over a circular buffer.
// Latency: buffer write, triggered and trig_addr are registered 1 cycle after the sample; copy_req/busy decode state.
// Backpressure: none on samples (dropped outside acquisition states); copy waits on copy_ready low-then-high.
module trigger_ctrl
  import trigger_pkg::*;
#(
  parameter int DEPTH        = 512,
  parameter int PRE_LEN      = 128,
  parameter int AUTO_TIMEOUT = 4096,
  parameter int HOLDOFF      = 64
) (
  input  logic           clk,
  input  logic           rst,
  trigger_ctrl_if.slave  bus
);

  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(AUTO_TIMEOUT + DEPTH + HOLDOFF) + 1;
  localparam int POST_LAST = DEPTH - PRE_LEN - 2;

  trig_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_started, w_started_nxt;
  logic              w_fire, w_force;
  logic              w_acq, w_wr, w_hit;

  logic [ADDR_W-1:0]   r_ptr;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [SAMPLE_W-1:0] r_wr_data;
  logic                r_triggered;
  logic [ADDR_W-1:0]   r_trig_addr;
  logic                r_auto_trig;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_acq = (r_state == ST_PRE_FILL) || (r_state == ST_ARMED) || (r_state == ST_POST);
  assign w_wr  = w_acq && bus.sample_valid;

  trigger_detect u_detect (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_acq),
    .i_vld    (w_wr),
    .i_sample (bus.sample),
    .i_level  (bus.trig_level),
    .i_slope  (bus.trig_slope),
    .o_hit    (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_started <= w_started_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_started_nxt = r_started;
    w_fire        = 1'b0;
    w_force       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt     = '0;
        w_started_nxt = 1'b0;
        if (bus.mode == MODE_AUTO || bus.mode == MODE_NORMAL ||
            (bus.mode == MODE_SINGLE && bus.arm))
          w_state_nxt = ST_PRE_FILL;
      end
      ST_PRE_FILL: begin
        if (w_wr) begin
          if (r_cnt >= CNT_W'(PRE_LEN - 1)) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt);
          end
        end
      end
      ST_ARMED: begin
        if (w_wr) begin
          if (w_hit) begin
            w_fire      = 1'b1;
            w_state_nxt = ST_POST;
            w_cnt_nxt   = '0;
          end else if (bus.mode == MODE_AUTO && r_cnt >= CNT_W'(AUTO_TIMEOUT - 1)) begin
            // Timeout sample becomes the trigger point; >= covers a late switch into auto mode.
            w_fire      = 1'b1;
            w_force     = 1'b1;
            w_state_nxt = ST_POST;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt);
          end
        end
      end
      ST_POST: begin
        // The trigger sample was the first post sample, so count the remaining ones.
        if (w_wr) begin
          if (r_cnt >= CNT_W'(POST_LAST)) begin
            w_state_nxt = ST_COPY_REQ;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt);
          end
        end
      end
      ST_COPY_REQ: begin
        w_state_nxt   = ST_COPY_WAIT;
        w_cnt_nxt     = '0;
        w_started_nxt = 1'b0;
      end
      ST_COPY_WAIT: begin
        if (r_started) begin
          if (bus.copy_ready) begin
            w_state_nxt = ST_HOLDOFF;
            w_cnt_nxt   = '0;
          end
        end else if (!bus.copy_ready) begin
          w_started_nxt = 1'b1;
        end else if (r_cnt >= CNT_W'(1)) begin
          // Ready never dropped within two cycles: the copy is taken as started and already done.
          w_state_nxt = ST_HOLDOFF;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      ST_HOLDOFF: begin
        if (r_cnt >= CNT_W'(HOLDOFF - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (bus.mode == MODE_AUTO || bus.mode == MODE_NORMAL) ? ST_PRE_FILL : ST_IDLE;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Stop aborts everything except a copy already handed to the snapshot block.
    if (bus.mode == MODE_STOP && r_state != ST_COPY_REQ && r_state != ST_COPY_WAIT) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_fire      = 1'b0;
      w_force     = 1'b0;
    end
  end

  // Write port and trigger-point bookkeeping; r_ptr is the address the next sample lands at.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_triggered <= 1'b0;
      r_trig_addr <= '0;
      r_auto_trig <= 1'b0;
    end else begin
      r_wr_en     <= w_wr;
      r_triggered <= w_fire;
      if (w_wr) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= bus.sample;
        r_ptr     <= r_ptr + ADDR_W'(1);
      end
      if (w_fire) begin
        r_trig_addr <= r_ptr - ADDR_W'(PRE_LEN);
        r_auto_trig <= w_force;
      end
    end
  end

  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.copy_req  = (r_state == ST_COPY_REQ);
  assign bus.trig_addr = r_trig_addr;
  assign bus.triggered = r_triggered;
  assign bus.auto_trig = r_auto_trig;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_trigger_ctrl.sv
// tb_trigger_ctrl: directed scenarios for trigger_ctrl with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are read at that same point.
// Copy and trigger pulses are tallied on the falling edge.
`timescale 1ns/1ps
module tb_trigger_ctrl;
  import trigger_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n_copy = 0;
  int   n_trig = 0;

  always #5 clk = ~clk;

  trigger_ctrl_if #(.DEPTH(512)) bus ();

  trigger_ctrl #(
    .DEPTH(512), .PRE_LEN(128), .AUTO_TIMEOUT(4096), .HOLDOFF(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.copy_req)  n_copy++;
      if (bus.triggered) n_trig++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] s);
    bus.sample_valid = v;
    bus.sample       = s;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mode = MODE_STOP; bus.arm = 1'b0; bus.sample_valid = 1'b0; bus.sample = '0;
    bus.copy_ready = 1'b1; bus.trig_level = '0; bus.trig_slope = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic start(input trig_mode_t m);
    bus.mode = m;
    bus.sample_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mode = MODE_NORMAL; bus.arm = 1'b0; bus.sample_valid = 1'b1; bus.sample = 12'hABC;
    bus.copy_ready = 1'b1; bus.trig_level = '0; bus.trig_slope = 1'b0;
    step(); step();
    total++; if (bus.wr_en     !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0d want=0", bus.wr_en); end
    total++; if (bus.wr_addr   !== 9'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d want=0", bus.wr_addr); end
    total++; if (bus.wr_data   !== 12'd0) begin bad++; $display("FAIL reset_wr_data got=%0d want=0", bus.wr_data); end
    total++; if (bus.copy_req  !== 1'b0) begin bad++; $display("FAIL reset_copy_req got=%0d want=0", bus.copy_req); end
    total++; if (bus.trig_addr !== 9'd0) begin bad++; $display("FAIL reset_trig_addr got=%0d want=0", bus.trig_addr); end
    total++; if (bus.triggered !== 1'b0) begin bad++; $display("FAIL reset_triggered got=%0d want=0", bus.triggered); end
    total++; if (bus.auto_trig !== 1'b0) begin bad++; $display("FAIL reset_auto_trig got=%0d want=0", bus.auto_trig); end
    total++; if (bus.busy      !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d want=0", bus.busy); end
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    step();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL reset_exit_busy got=%0d want=1", bus.busy); end
  endtask

  task automatic test_rising_normal();
    int c0, t0;
    do_reset();
    bus.trig_level = 12'd2048; bus.trig_slope = 1'b0;
    c0 = n_copy; t0 = n_trig;
    start(MODE_NORMAL);
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 12'((i * 16) % 4096));
      if (i == 128) begin
        total++; if (bus.triggered !== 1'b1) begin bad++; $display("FAIL rise_triggered got=%0d want=1", bus.triggered); end
        total++; if (bus.trig_addr !== 9'd0) begin bad++; $display("FAIL rise_trig_addr got=%0d want=0", bus.trig_addr); end
        total++; if (bus.wr_addr !== 9'd128) begin bad++; $display("FAIL rise_wr_addr got=%0d want=128", bus.wr_addr); end
        total++; if (bus.wr_data !== 12'd2048) begin bad++; $display("FAIL rise_wr_data got=%0d want=2048", bus.wr_data); end
        total++; if (bus.auto_trig !== 1'b0) begin bad++; $display("FAIL rise_auto_trig got=%0d want=0", bus.auto_trig); end
      end
      if (i == 510) begin
        total++; if (bus.copy_req !== 1'b0 || n_copy != c0) begin bad++; $display("FAIL rise_early_copy got=%0d want=0", bus.copy_req); end
      end
      if (i == 511) begin
        total++; if (bus.copy_req !== 1'b1) begin bad++; $display("FAIL rise_copy_req got=%0d want=1", bus.copy_req); end
        total++; if (bus.wr_addr !== 9'd511) begin bad++; $display("FAIL rise_last_addr got=%0d want=511", bus.wr_addr); end
      end
    end
    drive(1'b0, 12'd0);
    total++; if (bus.copy_req !== 1'b0) begin bad++; $display("FAIL rise_copy_pulse_width got=%0d want=0", bus.copy_req); end
    total++; if (n_copy - c0 != 1) begin bad++; $display("FAIL rise_copy_count got=%0d want=1", n_copy - c0); end
    total++; if (n_trig - t0 != 1) begin bad++; $display("FAIL rise_trig_count got=%0d want=1", n_trig - t0); end
  endtask

  task automatic test_auto_falling();
    int c0, t0;
    do_reset();
    bus.trig_level = 12'd1000; bus.trig_slope = 1'b1;
    c0 = n_copy; t0 = n_trig;
    start(MODE_AUTO);
    // 128 pre-fill samples, forced trigger on the 4096th armed sample (overall index 4223).
    for (int k = 0; k <= 4606; k++) begin
      drive(1'b1, 12'd3000);
      if (k == 4222) begin
        total++; if (bus.triggered !== 1'b0 || n_trig != t0) begin bad++; $display("FAIL auto_early_trig got=%0d want=0", bus.triggered); end
      end
      if (k == 4223) begin
        total++; if (bus.triggered !== 1'b1) begin bad++; $display("FAIL auto_triggered got=%0d want=1", bus.triggered); end
        total++; if (bus.auto_trig !== 1'b1) begin bad++; $display("FAIL auto_flag got=%0d want=1", bus.auto_trig); end
        total++; if (bus.wr_addr !== 9'd127) begin bad++; $display("FAIL auto_wr_addr got=%0d want=127", bus.wr_addr); end
        total++; if (bus.trig_addr !== 9'd511) begin bad++; $display("FAIL auto_trig_addr got=%0d want=511", bus.trig_addr); end
      end
      if (k == 4606) begin
        total++; if (bus.copy_req !== 1'b1) begin bad++; $display("FAIL auto_copy_req got=%0d want=1", bus.copy_req); end
      end
    end
    bus.sample_valid = 1'b0;
    repeat (4) step();
    total++; if (bus.auto_trig !== 1'b1) begin bad++; $display("FAIL auto_flag_held got=%0d want=1", bus.auto_trig); end
    total++; if (n_copy - c0 != 1) begin bad++; $display("FAIL auto_copy_count got=%0d want=1", n_copy - c0); end
    total++; if (n_trig - t0 != 1) begin bad++; $display("FAIL auto_trig_count got=%0d want=1", n_trig - t0); end
  endtask

  task automatic test_single();
    int c0, t0, n, stray;
    do_reset();
    bus.trig_level = 12'd2048; bus.trig_slope = 1'b0;
    bus.mode = MODE_SINGLE;
    c0 = n_copy; t0 = n_trig;
    for (int i = 0; i < 5; i++) drive(1'b1, (i % 2 == 0) ? 12'd0 : 12'd4095);
    total++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin bad++; $display("FAIL single_no_arm busy=%0d wr_en=%0d want=0", bus.busy, bus.wr_en); end
    bus.arm = 1'b1;
    drive(1'b0, 12'd0);
    bus.arm = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_armed_busy got=%0d want=1", bus.busy); end
    for (int i = 0; i < 512; i++) drive(1'b1, (i == 128) ? 12'd4095 : 12'd0);
    total++; if (bus.copy_req !== 1'b1) begin bad++; $display("FAIL single_copy_req got=%0d want=1", bus.copy_req); end
    bus.sample_valid = 1'b0;
    bus.copy_ready = 1'b0;
    step(); step();
    bus.copy_ready = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin step(); n++; end
    total++; if (n != 65) begin bad++; $display("FAIL single_return_idle cycles=%0d want=65", n); end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i % 2 == 0) ? 12'd0 : 12'd4095);
      if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL single_rearm_stray got=%0d want=0", stray); end
    total++; if (n_copy - c0 != 1) begin bad++; $display("FAIL single_copy_count got=%0d want=1", n_copy - c0); end
    total++; if (n_trig - t0 != 1) begin bad++; $display("FAIL single_trig_count got=%0d want=1", n_trig - t0); end
  endtask

  task automatic test_copy_wait();
    int n, early;
    do_reset();
    bus.trig_level = 12'd2048; bus.trig_slope = 1'b0;
    start(MODE_NORMAL);
    for (int i = 0; i < 512; i++) drive(1'b1, (i == 128) ? 12'd4095 : 12'd0);
    total++; if (bus.copy_req !== 1'b1) begin bad++; $display("FAIL cw_copy_req got=%0d want=1", bus.copy_req); end
    bus.copy_ready = 1'b0;
    early = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 12'd0);
      if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1 || (i > 0 && bus.copy_req !== 1'b0)) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL cw_left_wait got=%0d want=0", early); end
    bus.copy_ready = 1'b1;
    n = 0;
    while (bus.wr_en !== 1'b1 && n < 300) begin step(); n++; end
    total++; if (n != 66) begin bad++; $display("FAIL cw_holdoff_cycles got=%0d want=66", n); end
    total++; if (bus.wr_addr !== 9'd0) begin bad++; $display("FAIL cw_rearm_addr got=%0d want=0", bus.wr_addr); end
  endtask

  task automatic test_reset_abort();
    int c1, stray;
    do_reset();
    bus.trig_level = 12'd2048; bus.trig_slope = 1'b0;
    start(MODE_NORMAL);
    for (int i = 0; i < 188; i++) drive(1'b1, (i == 138) ? 12'd4095 : 12'd0);
    total++; if (bus.trig_addr !== 9'd10) begin bad++; $display("FAIL abort_pre_trig_addr got=%0d want=10", bus.trig_addr); end
    rst = 1'b1;
    step();
    total++; if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.copy_req, bus.trig_addr, bus.triggered, bus.auto_trig, bus.busy} !== 36'd0) begin
      bad++; $display("FAIL abort_post_outputs got=%h want=0", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.copy_req, bus.trig_addr, bus.triggered, bus.auto_trig, bus.busy}); end
    rst = 1'b0; bus.mode = MODE_SINGLE;
    c1 = n_copy; stray = 0;
    for (int i = 0; i < 450; i++) begin
      drive(1'b1, 12'd0);
      if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) stray++;
    end
    total++; if (stray != 0 || n_copy != c1) begin bad++; $display("FAIL abort_post_resume stray=%0d copies=%0d want=0", stray, n_copy - c1); end

    do_reset();
    bus.trig_level = 12'd2048; bus.trig_slope = 1'b0;
    start(MODE_NORMAL);
    for (int i = 0; i < 512; i++) drive(1'b1, (i == 128) ? 12'd4095 : 12'd0);
    bus.copy_ready = 1'b0;
    repeat (3) drive(1'b0, 12'd0);
    rst = 1'b1;
    step();
    total++; if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.copy_req, bus.trig_addr, bus.triggered, bus.auto_trig, bus.busy} !== 36'd0) begin
      bad++; $display("FAIL abort_cw_outputs got=%h want=0", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.copy_req, bus.trig_addr, bus.triggered, bus.auto_trig, bus.busy}); end
    rst = 1'b0; bus.mode = MODE_SINGLE; bus.copy_ready = 1'b1;
    c1 = n_copy; stray = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.busy !== 1'b0 || bus.copy_req !== 1'b0) stray++;
    end
    total++; if (stray != 0 || n_copy != c1) begin bad++; $display("FAIL abort_cw_resume stray=%0d copies=%0d want=0", stray, n_copy - c1); end
  endtask

  task automatic test_sparse_wrap();
    int v, w, c, t0;
    logic vv;
    logic [11:0] s;
    do_reset();
    bus.trig_level = 12'd4095; bus.trig_slope = 1'b0;
    t0 = n_trig;
    start(MODE_NORMAL);
    v = 0; w = 0; c = 0;
    while (w < 520 && c < 5000) begin
      vv = (c % 3 == 0);
      s  = (v == 128) ? 12'd4095 : 12'(v % 64);
      drive(vv, s);
      if (vv) v++;
      c++;
      if (bus.wr_en === 1'b1) begin
        total++; if (bus.wr_addr !== 9'(w % 512)) begin bad++; $display("FAIL sparse_wr_addr w=%0d got=%0d want=%0d", w, bus.wr_addr, w % 512); end
        if (w < 512) begin
          s = (w == 128) ? 12'd4095 : 12'(w % 64);
          total++; if (bus.wr_data !== s) begin bad++; $display("FAIL sparse_wr_data w=%0d got=%0d want=%0d", w, bus.wr_data, s); end
        end
        if (w == 128) begin
          total++; if (bus.triggered !== 1'b1 || bus.trig_addr !== 9'd0) begin bad++; $display("FAIL sparse_trigger trig=%0d addr=%0d want=1,0", bus.triggered, bus.trig_addr); end
        end
        if (w == 511) begin
          total++; if (bus.copy_req !== 1'b1) begin bad++; $display("FAIL sparse_copy_req got=%0d want=1", bus.copy_req); end
        end
        w++;
      end
    end
    total++; if (w < 520) begin bad++; $display("FAIL sparse_timeout writes=%0d want=520", w); end
    total++; if (n_trig - t0 != 1) begin bad++; $display("FAIL sparse_trig_count got=%0d want=1", n_trig - t0); end
  endtask

  initial begin
    rst = 1'b1;
    bus.mode = MODE_STOP; bus.arm = 1'b0; bus.sample_valid = 1'b0; bus.sample = '0;
    bus.copy_ready = 1'b1; bus.trig_level = '0; bus.trig_slope = 1'b0;
    test_reset();
    test_rising_normal();
    test_auto_falling();
    test_single();
    test_copy_wait();
    test_reset_abort();
    test_sparse_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
